// File: rtl/clock_ratio_meter.sv
// clock_ratio_meter: measures the half-period of a slow toggling sig_in in clk_in cycles; optional min/max tracking under CLOCK_RATIO_METER_MINMAX_EN
module clock_ratio_meter #(
  parameter int MAX_DIV = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT = 4,
  localparam int CW = $clog2(MAX_DIV + 1),
  localparam int LW = $clog2(LOCK_COUNT + 1)
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          sig_in,
  output logic          meas_valid,
  output logic [CW-1:0] half_period,
  output logic          locked,
  output logic          timeout
`ifdef CLOCK_RATIO_METER_MINMAX_EN
  ,
  output logic [CW-1:0] hp_min,
  output logic [CW-1:0] hp_max
`endif
);
  localparam logic [CW-1:0] cnt_max = CW'(MAX_DIV - 1);
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic s, s_d, edge_q;
  logic [CW-1:0] cnt, sample;
  logic [LW-1:0] match, next_match;
  logic same, lock_hit, take;
  assign s = sync[SYNC_STAGES-1];
  assign sample = cnt + CW'(1);
  assign same = sample == half_period;
  assign next_match = same ? match + LW'(1) : LW'(1);
  assign lock_hit = next_match == LW'(LOCK_COUNT);
  assign take = edge_q && state != IDLE;
  // synchronize sig_in and register its edge so the FSM sees one clean pulse per transition
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      sync <= '0;
      s_d <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      s_d <= s;
      edge_q <= s ^ s_d;
    end
  end
  // interval counter and measure/lock/timeout state machine
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      match <= '0;
      meas_valid <= 1'b0;
      half_period <= '0;
      locked <= 1'b0;
      timeout <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      cnt <= edge_q ? '0 : (cnt == cnt_max) ? cnt : cnt + CW'(1);
      case (state)
        IDLE: begin
          if (edge_q) begin
            timeout <= 1'b0;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (edge_q) begin
            meas_valid <= 1'b1;
            half_period <= sample;
            match <= next_match;
            if (lock_hit) begin
              locked <= 1'b1;
              state <= LOCKED;
            end
          end else if (cnt == cnt_max) begin
            timeout <= 1'b1;
            locked <= 1'b0;
            match <= '0;
            state <= IDLE;
          end
        end
        LOCKED: begin
          if (edge_q) begin
            meas_valid <= 1'b1;
            half_period <= sample;
            if (!same) begin
              locked <= 1'b0;
              match <= LW'(1);
              state <= MEASURE;
            end
          end else if (cnt == cnt_max) begin
            timeout <= 1'b1;
            locked <= 1'b0;
            match <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CLOCK_RATIO_METER_MINMAX_EN
  // running extremes of every reported measurement; only reset clears them
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      hp_min <= '1;
      hp_max <= '0;
    end else if (take) begin
      hp_min <= (sample < hp_min) ? sample : hp_min;
      hp_max <= (sample > hp_max) ? sample : hp_max;
    end
  end
`endif
endmodule

// File: tb/tb_clock_ratio_meter.sv
// tb_clock_ratio_meter: scoreboard bench for clock_ratio_meter (MAX_DIV=16); covers CLOCK_RATIO_METER_MINMAX_EN when defined
module tb_clock_ratio_meter;
  localparam int MAX_DIV = 16;
  localparam int CW = $clog2(MAX_DIV + 1);
  typedef struct packed {
    logic [CW-1:0] hp;
    logic          lk;
  } exp_t;
  logic clk_in = 1'b0;
  logic reset = 1'b0;
  logic sig_in = 1'b0;
  logic meas_valid, locked, timeout;
  logic [CW-1:0] half_period;
`ifdef CLOCK_RATIO_METER_MINMAX_EN
  logic [CW-1:0] hp_min, hp_max;
`endif
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  always #5 clk_in = ~clk_in;
  clock_ratio_meter #(.MAX_DIV(MAX_DIV), .SYNC_STAGES(2), .LOCK_COUNT(4)) dut (
    .clk_in(clk_in),
    .reset(reset),
    .sig_in(sig_in),
    .meas_valid(meas_valid),
    .half_period(half_period),
    .locked(locked),
    .timeout(timeout)
`ifdef CLOCK_RATIO_METER_MINMAX_EN
    ,
    .hp_min(hp_min),
    .hp_max(hp_max)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int p, input int hp, input logic lk, input bit push);
    exp_t e;
    repeat (p) @(posedge clk_in);
    #1 sig_in = ~sig_in;
    if (push) begin
      e.hp = CW'(hp);
      e.lk = lk;
      q.push_back(e);
    end
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, meas_valid, 0);
    chk({tag, "_hp"}, half_period, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_timeout"}, timeout, 0);
`ifdef CLOCK_RATIO_METER_MINMAX_EN
    chk({tag, "_hp_min"}, hp_min, 31);
    chk({tag, "_hp_max"}, hp_max, 0);
`endif
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk_in);
        if (meas_valid === 1'b1) begin
          chk("valid_pending", 32'(q.size() != 0), 1);
          if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("half_period", half_period, e.hp);
            chk("locked", locked, e.lk);
            chk("timeout_at_valid", timeout, 0);
          end
        end
      end
    join_none
    repeat (3) @(posedge clk_in);
    #1 chk_cleared("reset");
    reset = 1'b1;
    step(2, 0, 0, 0);
    repeat (3) step(2, 2, 0, 1);
    repeat (2) step(2, 2, 1, 1);
    repeat (3) step(5, 5, 0, 1);
    repeat (2) step(5, 5, 1, 1);
    repeat (3) step(7, 7, 0, 1);
    step(7, 7, 1, 1);
    repeat (3) step(3, 3, 0, 1);
    step(3, 3, 1, 1);
    repeat (3) @(posedge clk_in);
    #1 chk("latency_before", meas_valid, 0);
    @(posedge clk_in);
    #1 chk("latency_pulse", meas_valid, 1);
    @(posedge clk_in);
    #1 chk("latency_after", meas_valid, 0);
    repeat (14) @(posedge clk_in);
    #1 chk("timeout_early", timeout, 0);
    @(posedge clk_in);
    #1 chk("timeout_set", timeout, 1);
    chk("timeout_unlock", locked, 0);
    chk("timeout_hp_hold", half_period, 3);
    step(3, 0, 0, 0);
    repeat (6) @(posedge clk_in);
    #1 chk("timeout_cleared", timeout, 0);
    chk("idle_edge_no_valid", meas_valid, 0);
    step(1, 7, 0, 1);
    repeat (3) step(1, 1, 0, 1);
    repeat (2) step(1, 1, 1, 1);
    repeat (3) step(16, 16, 0, 1);
    repeat (2) step(16, 16, 1, 1);
    repeat (8) @(posedge clk_in);
    #1 chk("max_no_timeout", timeout, 0);
    chk("max_locked", locked, 1);
    reset = 1'b0;
    sig_in = 1'b0;
    @(posedge clk_in);
    #1 chk_cleared("midreset");
    reset = 1'b1;
    repeat (5) @(posedge clk_in);
    #1 chk("post_reset_hp", half_period, 0);
    step(3, 0, 0, 0);
    step(4, 4, 0, 1);
    step(9, 9, 0, 1);
    step(2, 2, 0, 1);
    step(9, 9, 0, 1);
    repeat (8) @(posedge clk_in);
    #1 chk("final_hp", half_period, 9);
    chk("final_locked", locked, 0);
`ifdef CLOCK_RATIO_METER_MINMAX_EN
    chk("final_hp_min", hp_min, 2);
    chk("final_hp_max", hp_max, 9);
`endif
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
